// File: rtl/costas_ctrl_pkg.sv
// Shared state encoding for the Costas loop sequencing controller.
package costas_ctrl_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    FLUSH   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;
endpackage

// File: rtl/costas_loop_ctrl_if.sv
// Mode-request, phase-error and status bundle between the Costas datapath and its controller.
interface costas_loop_ctrl_if #(
  parameter int WIDTH = 16
);
  import costas_ctrl_pkg::*;

  logic               mode_req_bpsk;
  logic               mode_req_valid;
  logic               mode_req_ready;
  logic [WIDTH-1:0]   error_tdata;
  logic               error_tvalid;
  logic               is_bpsk;
  logic               loop_rst;
  logic               narrow_bw;
  logic               locked;
  logic [STATE_W-1:0] state;
  logic [7:0]         retry_cnt;

  modport master (
    output mode_req_bpsk, mode_req_valid, error_tdata, error_tvalid,
    input  mode_req_ready, is_bpsk, loop_rst, narrow_bw, locked, state, retry_cnt
  );

  modport slave (
    input  mode_req_bpsk, mode_req_valid, error_tdata, error_tvalid,
    output mode_req_ready, is_bpsk, loop_rst, narrow_bw, locked, state, retry_cnt
  );
endinterface

// File: rtl/err_mag_cmp.sv
// Saturating |err| against the lock threshold; purely combinational, good = |err| < LOCK_THRESH.
module err_mag_cmp #(
  parameter int WIDTH       = 16,
  parameter int LOCK_THRESH = 512
) (
  input  logic signed [WIDTH-1:0] err,
  output logic                    good
);
  localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [31:0]      THRESH_U = LOCK_THRESH;

  logic [WIDTH-1:0] err_u;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] mag;

  assign err_u = err;
  assign neg   = ~err_u + WIDTH'(1);

  // Negating the most negative value leaves the sign bit set; clamp it.
  always_comb begin
    mag = err_u;
    if (err_u[WIDTH-1]) begin
      mag = neg[WIDTH-1] ? MAG_MAX : neg;
    end
  end

  assign good = (32'(mag) < THRESH_U);
endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas loop sequencer: flush / acquire / lock FSM with hysteresis and mode-change flushing.
// Outputs registered; ready = state != FLUSH. Optional acquisition timeout via COSTAS_CTRL_TIMEOUT_EN.
module costas_loop_ctrl
  import costas_ctrl_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LOCK_THRESH  = 512,
  parameter int LOCK_CNT     = 1024,
  parameter int UNLOCK_CNT   = 256,
  parameter int FLUSH_CYCLES = 16,
  parameter int ACQ_TIMEOUT  = 65536
) (
  input  logic               clk,
  input  logic               rst,
  costas_loop_ctrl_if.slave  bus
);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_SAT  = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);
  localparam logic [FL_W-1:0]   FL_INIT   = FL_W'(FLUSH_CYCLES - 1);

  if (LOCK_CNT < 1 || UNLOCK_CNT < 1 || FLUSH_CYCLES < 1 || ACQ_TIMEOUT < 1 || LOCK_THRESH < 0)
  begin : g_param_chk
    $error("costas_loop_ctrl: counts must be >= 1 and threshold >= 0");
  end

  state_t            state, state_nx;
  logic [GOOD_W-1:0] good_cnt, good_nx;
  logic [BAD_W-1:0]  bad_cnt, bad_nx;
  logic [FL_W-1:0]   flush_cnt, flush_nx;
  logic              bpsk_q, bpsk_nx;
  logic              loop_rst_q, narrow_q, locked_q;
  logic              err_good;
  logic              ready;
  logic              change;
  logic              timeout;

  err_mag_cmp #(
    .WIDTH       (WIDTH),
    .LOCK_THRESH (LOCK_THRESH)
  ) u_err_mag_cmp (
    .err  (bus.error_tdata),
    .good (err_good)
  );

  assign ready  = (state != FLUSH);
  assign change = bus.mode_req_valid && ready && (bus.mode_req_bpsk != bpsk_q);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    flush_nx = flush_cnt;
    bpsk_nx  = bpsk_q;
    case (state)
      FLUSH: begin
        good_nx = '0;
        bad_nx  = '0;
        if (flush_cnt == '0) state_nx = ACQUIRE;
        else                 flush_nx = flush_cnt - FL_W'(1);
      end
      ACQUIRE: begin
        if (bus.error_tvalid) begin
          if (!err_good) begin
            good_nx = '0;
          end else if (good_cnt == GOOD_LAST) begin
            good_nx  = GOOD_SAT;
            bad_nx   = '0;
            state_nx = LOCKED;
          end else begin
            good_nx = good_cnt + GOOD_W'(1);
          end
        end
        // A lock on the same edge wins over the timeout.
        if (state_nx == ACQUIRE && timeout) begin
          state_nx = FLUSH;
          flush_nx = FL_INIT;
          good_nx  = '0;
        end
      end
      LOCKED: begin
        if (bus.error_tvalid) begin
          if (err_good) begin
            bad_nx = '0;
          end else if (bad_cnt == BAD_LAST) begin
            bad_nx   = '0;
            good_nx  = '0;
            state_nx = ACQUIRE;
          end else begin
            bad_nx = bad_cnt + BAD_W'(1);
          end
        end
      end
      default: begin
        state_nx = FLUSH;
        flush_nx = FL_INIT;
      end
    endcase
    // Mode changes override every other transition and always re-flush the loop.
    if (change) begin
      state_nx = FLUSH;
      flush_nx = FL_INIT;
      bpsk_nx  = bus.mode_req_bpsk;
      good_nx  = '0;
      bad_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      flush_cnt  <= FL_INIT;
      bpsk_q     <= 1'b1;
      loop_rst_q <= 1'b1;
      narrow_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      good_cnt   <= good_nx;
      bad_cnt    <= bad_nx;
      flush_cnt  <= flush_nx;
      bpsk_q     <= bpsk_nx;
      loop_rst_q <= (state_nx == FLUSH);
      narrow_q   <= (state_nx == LOCKED);
      locked_q   <= (state_nx == LOCKED);
    end
  end

`ifdef COSTAS_CTRL_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACQ_TIMEOUT - 1);

  logic [TMR_W-1:0] acq_tmr;
  logic [7:0]       retry_q;

  assign timeout = (acq_tmr == TMR_LAST);

  // Timer restarts on every entry to ACQUIRE; an ACQUIRE->FLUSH without a mode change is a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      acq_tmr <= '0;
      retry_q <= '0;
    end else begin
      acq_tmr <= (state == ACQUIRE && state_nx == ACQUIRE) ? acq_tmr + TMR_W'(1) : '0;
      if (state == ACQUIRE && state_nx == FLUSH && !change && retry_q != 8'hFF)
        retry_q <= retry_q + 8'd1;
    end
  end

  assign bus.retry_cnt = retry_q;
`else
  assign timeout       = 1'b0;
  assign bus.retry_cnt = '0;
`endif

  assign bus.mode_req_ready = ready;
  assign bus.is_bpsk        = bpsk_q;
  assign bus.loop_rst       = loop_rst_q;
  assign bus.narrow_bw      = narrow_q;
  assign bus.locked         = locked_q;
  assign bus.state          = state;
endmodule
